// File: rtl/mc_controller.sv
// mc_controller: multicycle RV32I control FSM with MEM_LATENCY wait states.
// Optional ILLEGAL_TRAP_EN adds a HALT state and the IllegalInstr output.
module mc_controller #(
    parameter int MEM_LATENCY = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       LT,
    input  logic       LTU,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ImmSrc,
`ifdef ILLEGAL_TRAP_EN
    output logic       IllegalInstr,
`endif
    output logic [3:0] ALUControl
);
    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI,
        ALUWB, BRANCH, JAL, JALR, LUI, AUIPC
`ifdef ILLEGAL_TRAP_EN
        , HALT
`endif
    } state_t;

    state_t     state, dec_next;
    logic [2:0] cnt;
    logic       last, memst, taken, pcupdate, irw, mw, rw;
    logic [3:0] alu_fn;

    assign memst = state inside {FETCH, MEMREAD, MEMWRITE};
    assign last  = cnt == 3'(MEM_LATENCY);
    assign taken = (funct3[2:1] == 2'b01) ? 1'b0 :
                   ((funct3[2] ? (funct3[1] ? LTU : LT) : Zero) ^ funct3[0]);

    always_comb begin
        dec_next = FETCH;
        case (op)
            7'b0000011, 7'b0100011: dec_next = MEMADR;
            7'b0110011: dec_next = EXECR;
            7'b0010011: dec_next = EXECI;
            7'b1100011: dec_next = BRANCH;
            7'b1101111: dec_next = JAL;
            7'b1100111: dec_next = JALR;
            7'b0110111: dec_next = LUI;
            7'b0010111: dec_next = AUIPC;
`ifdef ILLEGAL_TRAP_EN
            default:    dec_next = HALT;
`else
            default:    dec_next = FETCH;
`endif
        endcase
`ifdef ILLEGAL_TRAP_EN
        if (op == 7'b1100011 && funct3[2:1] == 2'b01) dec_next = HALT;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
            cnt   <= '0;
        end else begin
            cnt <= (memst && !last) ? cnt + 3'd1 : 3'd0;
            case (state)
                FETCH:    if (last) state <= DECODE;
                DECODE:   state <= dec_next;
                MEMADR:   state <= op[5] ? MEMWRITE : MEMREAD;
                MEMREAD:  if (last) state <= MEMWB;
                MEMWRITE: if (last) state <= FETCH;
                EXECR, EXECI, JAL, JALR, LUI, AUIPC: state <= ALUWB;
`ifdef ILLEGAL_TRAP_EN
                HALT:     state <= HALT;
`endif
                default:  state <= FETCH;
            endcase
        end
    end

    always_comb begin
        case (funct3)
            3'b000:  alu_fn = (state == EXECR && funct7b5) ? 4'd1 : 4'd0;
            3'b001:  alu_fn = 4'd7;
            3'b010:  alu_fn = 4'd5;
            3'b011:  alu_fn = 4'd6;
            3'b100:  alu_fn = 4'd4;
            3'b101:  alu_fn = funct7b5 ? 4'd9 : 4'd8;
            3'b110:  alu_fn = 4'd3;
            default: alu_fn = 4'd2;
        endcase
    end

    always_comb begin
        case (op)
            7'b0100011:             ImmSrc = 3'b001;
            7'b1100011:             ImmSrc = 3'b010;
            7'b0110111, 7'b0010111: ImmSrc = 3'b011;
            7'b1101111:             ImmSrc = 3'b100;
            default:                ImmSrc = 3'b000;
        endcase
    end

    always_comb begin
        pcupdate   = 1'b0;
        irw        = 1'b0;
        mw         = 1'b0;
        rw         = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUControl = 4'd0;
        case (state)
            FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                irw       = last;
                pcupdate  = last;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            MEMREAD: AdrSrc = 1'b1;
            MEMWB: begin
                ResultSrc = 2'b01;
                rw        = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc = 1'b1;
                mw     = last;
            end
            EXECR: begin
                ALUSrcA    = 2'b10;
                ALUControl = alu_fn;
            end
            EXECI: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = alu_fn;
            end
            ALUWB: rw = 1'b1;
            BRANCH: begin
                ALUSrcA    = 2'b10;
                ALUControl = 4'd1;
            end
            JAL: begin
                ALUSrcA  = 2'b01;
                ALUSrcB  = 2'b10;
                pcupdate = 1'b1;
            end
            JALR: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                pcupdate  = 1'b1;
            end
            LUI: begin
                ALUSrcB    = 2'b01;
                ALUControl = 4'd10;
            end
            AUIPC: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            default: ;
        endcase
    end

    // Enables are suppressed during reset so an abandoned instruction writes nothing.
    assign PCWrite  = !reset && (pcupdate || (state == BRANCH && taken));
    assign IRWrite  = !reset && irw;
    assign MemWrite = !reset && mw;
    assign RegWrite = !reset && rw;
`ifdef ILLEGAL_TRAP_EN
    assign IllegalInstr = state == HALT;
`endif
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: scoreboard bench driving two controllers (MEM_LATENCY 0 and 2).
module tb_mc_controller;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0, rst1, funct7b5, Zero, LT, LTU;
    logic [6:0] op;
    logic [2:0] funct3;
    logic [1:0] pcw, adr, mw, irw, rw;
    logic [1:0] rs[2], sa[2], sb[2];
    logic [2:0] imm[2];
    logic [3:0] alu[2];

    mc_controller #(.MEM_LATENCY(0)) d0 (
        .clk(clk), .reset(rst0), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .LT(LT), .LTU(LTU), .PCWrite(pcw[0]), .AdrSrc(adr[0]),
        .MemWrite(mw[0]), .IRWrite(irw[0]), .RegWrite(rw[0]), .ResultSrc(rs[0]),
        .ALUSrcA(sa[0]), .ALUSrcB(sb[0]), .ImmSrc(imm[0]), .ALUControl(alu[0])
    );
    mc_controller #(.MEM_LATENCY(2)) d1 (
        .clk(clk), .reset(rst1), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .LT(LT), .LTU(LTU), .PCWrite(pcw[1]), .AdrSrc(adr[1]),
        .MemWrite(mw[1]), .IRWrite(irw[1]), .RegWrite(rw[1]), .ResultSrc(rs[1]),
        .ALUSrcA(sa[1]), .ALUSrcB(sb[1]), .ImmSrc(imm[1]), .ALUControl(alu[1])
    );

    typedef struct {
        int          w;
        logic [17:0] e;
        string       nm;
    } exp_t;
    exp_t q[$];
    int total = 0, bad = 0;

    localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, PASSB = 4'd10;
    localparam logic [17:0] EN_MASK = 18'b10_1110_0000_0000_0000;
    localparam logic [6:0] OPS[9] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
        7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

    function automatic logic [17:0] obs(int w);
        return {pcw[w], adr[w], mw[w], irw[w], rw[w], rs[w], sa[w], sb[w], imm[w], alu[w]};
    endfunction

    function automatic logic [2:0] imm_of(logic [6:0] o);
        case (o)
            7'b0100011: return 3'd1;
            7'b1100011: return 3'd2;
            7'b0110111, 7'b0010111: return 3'd3;
            7'b1101111: return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic [3:0] alu_of(logic [2:0] f3, logic f7, logic r);
        case (f3)
            3'd0: return (r && f7) ? SUB : ADD;
            3'd1: return 4'd7;
            3'd2: return 4'd5;
            3'd3: return 4'd6;
            3'd4: return 4'd4;
            3'd5: return f7 ? 4'd9 : 4'd8;
            3'd6: return 4'd3;
            default: return 4'd2;
        endcase
    endfunction

    function automatic logic taken_of(logic [2:0] f3, logic z, logic l, logic lu);
        case (f3)
            3'd0: return z;
            3'd1: return !z;
            3'd4: return l;
            3'd5: return !l;
            3'd6: return lu;
            3'd7: return !lu;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [17:0] v(logic p, logic a, logic m, logic i, logic r,
                                      logic [1:0] res, logic [1:0] sra, logic [1:0] srb,
                                      logic [3:0] f);
        return {p, a, m, i, r, res, sra, srb, imm_of(op), f};
    endfunction

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [17:0] act;
            e = q.pop_front();
            act = obs(e.w);
            total++;
            if (act !== e.e) begin
                bad++;
                $display("FAIL %s dut%0d: got %b want %b", e.nm, e.w, act, e.e);
            end
        end
    end

    task automatic push(int w, logic [17:0] e, string nm);
        exp_t x;
        x.w = w;
        x.e = e;
        x.nm = nm;
        q.push_back(x);
    endtask

    task automatic do_reset(int w);
        rst0 = 1'b1;
        rst1 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            push(w, v(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, ADD), "reset");
            @(posedge clk);
            #1;
        end
        if (w == 0) rst0 = 1'b0;
        else rst1 = 1'b0;
    endtask

    task automatic do_instr(int w, logic [6:0] o, logic [2:0] f3, logic f7, logic z,
                            logic l, logic lu, int abort, string nm);
        logic [17:0] s[$];
        logic [17:0] wb;
        int lat;
        lat = (w == 0) ? 0 : 2;
        op = o; funct3 = f3; funct7b5 = f7; Zero = z; LT = l; LTU = lu;
        wb = v(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, ADD);
        for (int i = 0; i <= lat; i++)
            s.push_back(v(i == lat, 0, 0, i == lat, 0, 2'b10, 2'b00, 2'b10, ADD));
        s.push_back(v(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, ADD));
        case (o)
            7'b0000011: begin
                s.push_back(v(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, ADD));
                for (int i = 0; i <= lat; i++) s.push_back(v(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, ADD));
                s.push_back(v(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, ADD));
            end
            7'b0100011: begin
                s.push_back(v(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, ADD));
                for (int i = 0; i <= lat; i++) s.push_back(v(0, 1, i == lat, 0, 0, 2'b00, 2'b00, 2'b00, ADD));
            end
            7'b0110011: begin
                s.push_back(v(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, alu_of(f3, f7, 1'b1)));
                s.push_back(wb);
            end
            7'b0010011: begin
                s.push_back(v(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, alu_of(f3, f7, 1'b0)));
                s.push_back(wb);
            end
            7'b1100011: s.push_back(v(taken_of(f3, z, l, lu), 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, SUB));
            7'b1101111: begin
                s.push_back(v(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, ADD));
                s.push_back(wb);
            end
            7'b1100111: begin
                s.push_back(v(1, 0, 0, 0, 0, 2'b10, 2'b10, 2'b01, ADD));
                s.push_back(wb);
            end
            7'b0110111: begin
                s.push_back(v(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, PASSB));
                s.push_back(wb);
            end
            7'b0010111: begin
                s.push_back(v(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, ADD));
                s.push_back(wb);
            end
            default: ;
        endcase
        for (int i = 0; i < s.size(); i++) begin
            if (i == abort) begin
                if (w == 0) rst0 = 1'b1;
                else rst1 = 1'b1;
                push(w, s[i] & ~EN_MASK, {nm, "_abort"});
                @(posedge clk);
                #1;
                rst0 = (w != 0);
                rst1 = (w == 0);
                return;
            end
            push(w, s[i], $sformatf("%s_c%0d", nm, i + 1));
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rand_instr(int w);
        logic [6:0] o;
        int k;
        k = $urandom_range(0, 9);
        if (k < 9) o = OPS[k];
        else begin
            o = 7'($urandom);
            while (o inside {OPS}) o = 7'($urandom);
        end
        do_instr(w, o, 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), -1, "rand");
    endtask

    initial begin
        rst0 = 1'b1; rst1 = 1'b1;
        op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; Zero = 1'b0; LT = 1'b0; LTU = 1'b0;
        @(posedge clk);
        #1;
        do_reset(0);
        do_instr(0, 7'b0110011, 3'b000, 0, 0, 0, 0, -1, "add");
        do_instr(0, 7'b0110011, 3'b000, 1, 0, 0, 0, -1, "sub");
        do_instr(0, 7'b0010011, 3'b101, 1, 0, 0, 0, -1, "srai");
        do_instr(0, 7'b0010011, 3'b000, 1, 0, 0, 0, -1, "addi_f7");
        do_instr(0, 7'b0000011, 3'b010, 0, 0, 0, 0, -1, "lw");
        do_instr(0, 7'b1100011, 3'b000, 0, 1, 0, 0, -1, "beq_t");
        do_instr(0, 7'b1100011, 3'b000, 0, 0, 0, 0, -1, "beq_nt");
        do_instr(0, 7'b1100011, 3'b110, 0, 0, 0, 1, -1, "bltu_t");
        do_instr(0, 7'b1100011, 3'b010, 0, 1, 1, 1, -1, "b010");
        do_instr(0, 7'b1101111, 3'b000, 0, 0, 0, 0, 2, "jal_rst");
        do_instr(0, 7'b1101111, 3'b000, 0, 0, 0, 0, -1, "jal");
        do_instr(0, 7'b1100111, 3'b000, 0, 0, 0, 0, -1, "jalr");
        do_instr(0, 7'b0110111, 3'b000, 0, 0, 0, 0, -1, "lui");
        do_instr(0, 7'b0010111, 3'b000, 0, 0, 0, 0, -1, "auipc");
        do_instr(0, 7'b1111111, 3'b000, 0, 0, 0, 0, -1, "op7f");
        for (int n = 0; n < 150; n++) rand_instr(0);
        do_reset(1);
        do_instr(1, 7'b0100011, 3'b010, 0, 0, 0, 0, -1, "sw_l2");
        do_instr(1, 7'b0000011, 3'b010, 0, 0, 0, 0, -1, "lw_l2");
        do_instr(1, 7'b0000011, 3'b010, 0, 0, 0, 0, 3, "lw_l2_rst");
        do_instr(1, 7'b1100011, 3'b001, 0, 0, 0, 0, -1, "bne_l2");
        for (int n = 0; n < 100; n++) rand_instr(1);
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
